// File: rtl/chip_valve_sequencer.sv
// chip_valve_sequencer: pneumatic valve/pump sequencer for the ChIP chip (open group, pump, close, done)
// Ports: clk, rst (async, active-high); cmd_valid/cmd_ready/cmd_op/cmd_sel/cmd_count command handshake;
// abort early stop; *_ctrl valve lines and pump1..3 (1 = pressurised/closed); busy, done and err status.
// Build option PUMP_REVERSE_EN adds the cmd_rev input, which selects the reverse peristaltic sequence.
module chip_valve_sequencer #(
  parameter int STEP_TICKS   = 1000,
  parameter int SETTLE_TICKS = 500,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
`ifdef PUMP_REVERSE_EN
  input  logic             cmd_rev,
`endif
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [2:0]       cmd_sel,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             abort,
  output logic [4:0]       inlet_ctrl,
  output logic             prep_inlet_ctrl,
  output logic             stage_inlet_ctrl,
  output logic             stage_outlet_ctrl,
  output logic             collect_ctrl,
  output logic             bead_ctrl,
  output logic             pump1,
  output logic             pump2,
  output logic             pump3,
  output logic             busy,
  output logic             done,
  output logic             err
);
  localparam int TMAX = STEP_TICKS > SETTLE_TICKS ? STEP_TICKS : SETTLE_TICKS;
  localparam int TW = TMAX > 1 ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] SET_END = TW'(SETTLE_TICKS - 1);
  localparam logic [TW-1:0] STEP_END = TW'(STEP_TICKS - 1);
  typedef enum logic [1:0] {IDLE, SETTLE, RUN, CLOSE} state_t;
  state_t state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [2:0] sel_q, sel_d, ph_q, ph_d, idx;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic done_q, done_d, err_q, err_d, bad, open_g;
  logic [2:0] pat;
`ifdef PUMP_REVERSE_EN
  logic rev_q, rev_d;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      op_q <= '0;
      sel_q <= '0;
      ph_q <= '0;
      rem_q <= '0;
      tmr_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
`ifdef PUMP_REVERSE_EN
      rev_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      sel_q <= sel_d;
      ph_q <= ph_d;
      rem_q <= rem_d;
      tmr_q <= tmr_d;
      done_q <= done_d;
      err_q <= err_d;
`ifdef PUMP_REVERSE_EN
      rev_q <= rev_d;
`endif
    end
  assign bad = cmd_count == '0 || (cmd_op == 2'd0 && cmd_sel > 3'd4);
  // rem_q counts remaining pump cycles; a cycle ends after step 5 expires
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    sel_d = sel_q;
    ph_d = ph_q;
    rem_d = rem_q;
    tmr_d = tmr_q + 1'b1;
    done_d = 1'b0;
    err_d = 1'b0;
`ifdef PUMP_REVERSE_EN
    rev_d = rev_q;
`endif
    case (state_q)
      IDLE: begin
        tmr_d = '0;
        if (cmd_valid && bad) err_d = 1'b1;
        else if (cmd_valid) begin
          state_d = SETTLE;
          op_d = cmd_op;
          sel_d = cmd_sel;
          rem_d = cmd_count;
`ifdef PUMP_REVERSE_EN
          rev_d = cmd_rev;
`endif
        end
      end
      SETTLE: begin
        if (abort) begin
          state_d = CLOSE;
          tmr_d = '0;
        end else if (tmr_q == SET_END) begin
          state_d = RUN;
          tmr_d = '0;
          ph_d = '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = CLOSE;
          tmr_d = '0;
        end else if (tmr_q == STEP_END) begin
          tmr_d = '0;
          ph_d = ph_q == 3'd5 ? 3'd0 : ph_q + 3'd1;
          if (ph_q == 3'd5) begin
            rem_d = rem_q - 1'b1;
            if (rem_q == CNT_W'(1)) state_d = CLOSE;
          end
        end
      end
      default: begin
        if (tmr_q == SET_END) begin
          state_d = IDLE;
          done_d = 1'b1;
          tmr_d = '0;
        end
      end
    endcase
  end
`ifdef PUMP_REVERSE_EN
  assign idx = rev_q ? 3'd5 - ph_q : ph_q;
`else
  assign idx = ph_q;
`endif
  assign pat = idx == 3'd0 ? 3'b101 : idx == 3'd1 ? 3'b100 : idx == 3'd2 ? 3'b110 :
               idx == 3'd3 ? 3'b010 : idx == 3'd4 ? 3'b011 : 3'b001;
  // Lines decode from registered state only, so async reset closes everything immediately
  assign open_g = state_q == SETTLE || state_q == RUN;
  assign inlet_ctrl = open_g && op_q == 2'd0 ? ~(5'b00001 << sel_q) : 5'b11111;
  assign prep_inlet_ctrl = ~(open_g && op_q == 2'd0);
  assign stage_inlet_ctrl = ~(open_g && op_q != 2'd0);
  assign stage_outlet_ctrl = ~(open_g && op_q == 2'd1);
  assign collect_ctrl = ~(open_g && op_q == 2'd2);
  assign bead_ctrl = ~(open_g && op_q == 2'd3);
  assign {pump1, pump2, pump3} = state_q == RUN && op_q != 2'd0 ? pat : 3'b111;
  assign cmd_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign err = err_q;
endmodule

// File: tb/tb_chip_valve_sequencer.sv
// tb_chip_valve_sequencer: directed checks of the valve sequencer with STEP_TICKS=2, SETTLE_TICKS=3
module tb_chip_valve_sequencer;
  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, abort = 1'b0;
  logic [1:0] cmd_op = '0;
  logic [2:0] cmd_sel = '0;
  logic [7:0] cmd_count = '0;
  logic [4:0] inlet_ctrl;
  logic prep_inlet_ctrl, stage_inlet_ctrl, stage_outlet_ctrl, collect_ctrl, bead_ctrl;
  logic pump1, pump2, pump3, busy, done, err, cmd_ready;
  logic [12:0] lines;
  int n_cmp = 0, n_bad = 0;
`ifdef PUMP_REVERSE_EN
  logic cmd_rev = 1'b0;
`endif
  always #5 clk = ~clk;
  chip_valve_sequencer #(.STEP_TICKS(2), .SETTLE_TICKS(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid),
`ifdef PUMP_REVERSE_EN
    .cmd_rev(cmd_rev),
`endif
    .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_sel(cmd_sel), .cmd_count(cmd_count), .abort(abort),
    .inlet_ctrl(inlet_ctrl), .prep_inlet_ctrl(prep_inlet_ctrl), .stage_inlet_ctrl(stage_inlet_ctrl),
    .stage_outlet_ctrl(stage_outlet_ctrl), .collect_ctrl(collect_ctrl), .bead_ctrl(bead_ctrl),
    .pump1(pump1), .pump2(pump2), .pump3(pump3), .busy(busy), .done(done), .err(err)
  );
  assign lines = {inlet_ctrl, prep_inlet_ctrl, stage_inlet_ctrl, stage_outlet_ctrl, collect_ctrl,
                  bead_ctrl, pump1, pump2, pump3};
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string tag, logic [12:0] o, logic [12:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask
  // Expected lines for cycle c after accept; ab>0 is the cycle during which abort is held
  function automatic logic [12:0] exp_lines(int op, int sel, int cnt, bit rev, int c, int ab);
    logic [2:0] pt [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
    logic [12:0] l = '1;
    logic [4:0] m;
    int last = ab > 0 ? ab : 3 + cnt * 12;
    int s;
    if (c >= 1 && c <= last) begin
      case (op)
        0: begin m = 5'b00001 << sel; l[12:8] = ~m; l[7] = 1'b0; end
        1: begin l[6] = 1'b0; l[5] = 1'b0; end
        2: begin l[6] = 1'b0; l[4] = 1'b0; end
        default: begin l[6] = 1'b0; l[3] = 1'b0; end
      endcase
      if (c >= 4 && op != 0) begin
        s = ((c - 4) / 2) % 6;
        l[2:0] = pt[rev ? 5 - s : s];
      end
    end
    return l;
  endfunction
  task automatic run_cmd(string tag, int op, int sel, int cnt, bit rev, int ab);
    int dn = (ab > 0 ? ab : 3 + cnt * 12) + 4;
    cmd_valid = 1'b1;
    cmd_op = op[1:0];
    cmd_sel = sel[2:0];
    cmd_count = cnt[7:0];
`ifdef PUMP_REVERSE_EN
    cmd_rev = rev;
`endif
    tick();
    cmd_valid = 1'b0;
    for (int c = 1; c <= dn; c++) begin
      chk($sformatf("%s lines c%0d", tag, c), lines, exp_lines(op, sel, cnt, rev, c, ab));
      chk($sformatf("%s done c%0d", tag, c), 13'(done), 13'(c == dn));
      chk($sformatf("%s busy c%0d", tag, c), 13'(busy), 13'(c != dn));
      if (c == ab) abort = 1'b1;
      tick();
      abort = 1'b0;
    end
    chk({tag, " done_low"}, 13'(done), 13'd0);
  endtask
  task automatic reject(string tag, int op, int sel, int cnt);
    cmd_valid = 1'b1;
    cmd_op = op[1:0];
    cmd_sel = sel[2:0];
    cmd_count = cnt[7:0];
    tick();
    cmd_valid = 1'b0;
    chk({tag, " err"}, 13'(err), 13'd1);
    chk({tag, " ready"}, 13'(cmd_ready), 13'd1);
    chk({tag, " busy"}, 13'(busy), 13'd0);
    chk({tag, " lines"}, lines, 13'h1FFF);
    tick();
    chk({tag, " err_low"}, 13'(err), 13'd0);
    chk({tag, " lines2"}, lines, 13'h1FFF);
  endtask
  initial begin
    tick();
    tick();
    chk("rst lines", lines, 13'h1FFF);
    chk("rst flags", {10'd0, busy, done, err}, 13'd0);
    chk("rst ready", 13'(cmd_ready), 13'd1);
    rst = 1'b0;
    tick();
    run_cmd("pump", 1, 0, 2, 1'b0, 0);
    run_cmd("inlet3", 0, 3, 1, 1'b0, 0);
    run_cmd("inlet0", 0, 0, 1, 1'b0, 0);
    run_cmd("bead", 3, 0, 1, 1'b0, 0);
    reject("rej_sel5", 0, 5, 1);
    reject("rej_cnt0", 1, 0, 0);
    run_cmd("collect_abort", 2, 0, 4, 1'b0, 8);
    run_cmd("pump_abort_settle", 1, 0, 1, 1'b0, 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("idle_abort", {11'd0, busy, done}, 13'd0);
    cmd_valid = 1'b1;
    cmd_op = 2'd1;
    cmd_count = 8'd2;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("pre_rst lines", lines, 13'b1111110011100);
    #2 rst = 1'b1;
    #1;
    chk("async_rst lines", lines, 13'h1FFF);
    chk("async_rst busy", 13'(busy), 13'd0);
    chk("async_rst ready", 13'(cmd_ready), 13'd1);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst flags", {10'd0, busy, done, err}, 13'd0);
`ifdef PUMP_REVERSE_EN
    run_cmd("pump_rev", 1, 0, 1, 1'b1, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
